// File: rtl/dnn_sample_sequencer.sv
`default_nettype none
// ==========================================================================
// Module  : dnn_sample_sequencer
// Purpose : Issues sample fetches on DNN block boundaries and scores the
//           delayed predictions; scoring is built only with SEQ_ACCURACY_EN.
// Rev     : 1.0  initial release
// ==========================================================================
module dnn_sample_sequencer #(
    parameter int cpc     = 18,
    parameter int n_out   = 16,
    parameter int eta_w   = 4,
    parameter int aw      = 16,
    parameter int RES_LAT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(cpc)-1:0]   cycle_index,
    input  logic                     start,
    input  logic                     abort,
    input  logic [aw-1:0]            num_samples,
    input  logic [eta_w-1:0]         eta_cfg,
    input  logic                     sample_ready,
    input  logic [n_out-1:0]         ans_in,
    input  logic [n_out-1:0]         actL_alln,
    output logic [aw-1:0]            sample_idx,
    output logic                     sample_load,
    output logic [eta_w-1:0]         etapos0,
    output logic                     busy,
    output logic                     done,
    output logic [aw-1:0]            bubble_count,
    output logic [aw-1:0]            correct_count
);

    localparam int CIW = $clog2(cpc);
    localparam logic [CIW-1:0] LAST_CYC = CIW'(cpc - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 blk_end;
    logic                 start_acc;
    logic                 issue;
    logic                 bubble;
    logic                 shift_en;
    logic                 push_vld;
    logic                 older_empty;
    logic [RES_LAT-1:0]   vld;
    logic [aw-1:0]        num_lat;
    logic [eta_w-1:0]     eta_lat;

    assign blk_end = (cycle_index == LAST_CYC);
    assign busy    = (state == FEED) || (state == DRAIN);
    assign done    = (state == DONE);

    // The tail entry leaves on this block end, so only the older stages decide drain completion.
    always_comb begin
        older_empty = 1'b1;
        for (int i = 0; i < RES_LAT - 1; i++) begin
            if (vld[i]) older_empty = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        sample_load = 1'b0;
        start_acc   = 1'b0;
        issue       = 1'b0;
        bubble      = 1'b0;
        shift_en    = 1'b0;
        push_vld    = 1'b0;
        if (reset) begin
            state_nxt = IDLE;
        end else if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        start_acc = 1'b1;
                        state_nxt = (num_samples == '0) ? DONE : FEED;
                    end
                end
                FEED: begin
                    if (blk_end) begin
                        shift_en = 1'b1;
                        if (sample_ready) begin
                            sample_load = 1'b1;
                            issue       = 1'b1;
                            push_vld    = 1'b1;
                            if (sample_idx == num_lat - aw'(1)) state_nxt = DRAIN;
                        end else begin
                            bubble = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (blk_end) begin
                        shift_en = 1'b1;
                        if (older_empty) state_nxt = DONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_idx   <= '0;
            etapos0      <= '0;
            bubble_count <= '0;
            vld          <= '0;
            num_lat      <= '0;
            eta_lat      <= '0;
        end else if (abort) begin
            vld     <= '0;
            etapos0 <= '0;
        end else if (start_acc) begin
            num_lat      <= num_samples;
            eta_lat      <= eta_cfg;
            sample_idx   <= '0;
            bubble_count <= '0;
            vld          <= '0;
            etapos0      <= '0;
        end else if (shift_en) begin
            vld[0] <= push_vld;
            for (int i = 1; i < RES_LAT; i++) vld[i] <= vld[i-1];
            if (issue) begin
                etapos0    <= eta_lat;
                sample_idx <= sample_idx + aw'(1);
            end else begin
                etapos0 <= '0;
            end
            if (bubble && (bubble_count != '1)) bubble_count <= bubble_count + aw'(1);
        end
    end

`ifdef SEQ_ACCURACY_EN
    logic [n_out-1:0] ans_pipe [RES_LAT];
    logic [aw-1:0]    correct_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            correct_q <= '0;
            for (int i = 0; i < RES_LAT; i++) ans_pipe[i] <= '0;
        end else if (abort) begin
            for (int i = 0; i < RES_LAT; i++) ans_pipe[i] <= '0;
        end else if (start_acc) begin
            correct_q <= '0;
            for (int i = 0; i < RES_LAT; i++) ans_pipe[i] <= '0;
        end else if (shift_en) begin
            // Score the tail against the current prediction before it is shifted out.
            if (vld[RES_LAT-1] && (actL_alln == ans_pipe[RES_LAT-1]))
                correct_q <= correct_q + aw'(1);
            ans_pipe[0] <= push_vld ? ans_in : '0;
            for (int i = 1; i < RES_LAT; i++) ans_pipe[i] <= ans_pipe[i-1];
        end
    end

    assign correct_count = correct_q;
`else
    logic unused_acc;
    assign unused_acc    = ^{ans_in, actL_alln, vld[RES_LAT-1]};
    assign correct_count = '0;
`endif

endmodule
`default_nettype wire
